// File: rtl/pipeline_issue_ctrl.sv
// In-order issue controller: one-entry pending register, RAW hazard detection
// against the last HAZ_DEPTH issue slots, bubble insertion and perf counters.
module pipeline_issue_ctrl #(
  parameter int unsigned HAZ_DEPTH = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [31:0]      InstrIn,
  input  logic             InstrValid,
  output logic             InstrReady,
  input  logic             Flush,
  output logic [31:0]      IssueInstr,
  output logic             IssueValid,
  output logic [CNT_W-1:0] IssueCount,
  output logic [CNT_W-1:0] StallCount
);

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned REG_W   = 5;
  localparam logic [OP_W-1:0] OP_NOT = 6'b010001;

  logic                               pend_v;
  logic [INSTR_W-1:0]                 pend_i;
  logic [HAZ_DEPTH-1:0]               hist_wv;
  logic [HAZ_DEPTH-1:0][REG_W-1:0]    hist_wd;

  logic [OP_W-1:0]  pend_op_c;
  logic [REG_W-1:0] pend_rd_c;
  logic [REG_W-1:0] pend_rs_c;
  logic [REG_W-1:0] pend_rt_c;
  logic             op_valid_c;
  logic             reads_rt_c;
  logic             hazard_c;
  logic             issue_c;
  logic             accept_c;
  logic             push_wv_c;
  logic             stall_c;

  // Field decode of the pending word; invalid opcodes read and write nothing.
  always_comb begin
    pend_op_c  = pend_i[31:26];
    pend_rd_c  = pend_i[25:21];
    pend_rs_c  = pend_i[20:16];
    pend_rt_c  = pend_i[15:11];
    op_valid_c = (pend_op_c[5:4] == 2'b01);
    reads_rt_c = op_valid_c && !pend_op_c[3] && (pend_op_c != OP_NOT);
  end

  // RAW check of pending sources against every live history slot.
  always_comb begin
    hazard_c = 1'b0;
    for (int unsigned i = 0; i < HAZ_DEPTH; i++) begin
      if (hist_wv[i] && ((hist_wd[i] == pend_rs_c) ||
                         (reads_rt_c && (hist_wd[i] == pend_rt_c)))) begin
        hazard_c = 1'b1;
      end
    end
    hazard_c = hazard_c && pend_v && op_valid_c;
  end

  always_comb begin
    issue_c    = pend_v && !hazard_c && !Flush;
    InstrReady = !Flush && (!pend_v || issue_c);
    accept_c   = InstrValid && InstrReady;
    push_wv_c  = issue_c && op_valid_c;
    stall_c    = pend_v && hazard_c && !Flush;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pend_v <= 1'b0;
      pend_i <= '0;
    end else if (Flush) begin
      pend_v <= 1'b0;
    end else if (accept_c) begin
      pend_v <= 1'b1;
      pend_i <= InstrIn;
    end else if (issue_c) begin
      pend_v <= 1'b0;
    end
  end

  // Slot history: entry 0 always describes the word currently on IssueInstr.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hist_wv <= '0;
      hist_wd <= '0;
    end else if (Flush) begin
      hist_wv <= '0;
      hist_wd <= '0;
    end else begin
      hist_wv[0] <= push_wv_c;
      hist_wd[0] <= pend_rd_c;
      for (int unsigned i = 1; i < HAZ_DEPTH; i++) begin
        hist_wv[i] <= hist_wv[i-1];
        hist_wd[i] <= hist_wd[i-1];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      IssueInstr <= '0;
      IssueValid <= 1'b0;
    end else if (push_wv_c) begin
      IssueInstr <= pend_i;
      IssueValid <= 1'b1;
    end else begin
      IssueInstr <= '0;
      IssueValid <= 1'b0;
    end
  end

  // Saturating counters; they hold across Flush.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      IssueCount <= '0;
      StallCount <= '0;
    end else begin
      if (push_wv_c && (IssueCount != '1)) begin
        IssueCount <= IssueCount + CNT_W'(1);
      end
      if (stall_c && (StallCount != '1)) begin
        StallCount <= StallCount + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_issue_ctrl.sv
// Bench for pipeline_issue_ctrl: directed scenarios plus random streams
// checked against a slot-trace reference model.
module tb_pipeline_issue_ctrl;

  localparam int unsigned HAZ_DEPTH = 2;
  localparam int unsigned CNT_W     = 4;
  localparam int          CNT_MAX   = 15;

  localparam logic [31:0] ADDI = 32'h6821000A;
  localparam logic [31:0] ORI  = 32'h70420002;
  localparam logic [31:0] ADD  = 32'h48611000;
  localparam logic [31:0] NOTI = 32'h44E11000;

  logic             Clk = 1'b0;
  logic             Reset_n = 1'b0;
  logic [31:0]      InstrIn = '0;
  logic             InstrValid = 1'b0;
  logic             InstrReady;
  logic             Flush = 1'b0;
  logic [31:0]      IssueInstr;
  logic             IssueValid;
  logic [CNT_W-1:0] IssueCount;
  logic [CNT_W-1:0] StallCount;

  pipeline_issue_ctrl #(.HAZ_DEPTH(HAZ_DEPTH), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .InstrIn(InstrIn), .InstrValid(InstrValid),
    .InstrReady(InstrReady), .Flush(Flush), .IssueInstr(IssueInstr),
    .IssueValid(IssueValid), .IssueCount(IssueCount), .StallCount(StallCount)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Reference model: pending word plus a trace of registers written per output slot.
  bit          m_pv;
  logic [31:0] m_pi;
  int          trace[$];
  logic [31:0] m_out;
  bit          m_val;
  int          m_icnt;
  int          m_scnt;

  logic [31:0] src_q[$];
  logic        obs_ready;
  bit          exp_ready;
  bit          accepted;

  function automatic logic [31:0] mk(logic [5:0] op, int rd, int rs, int rt, logic [10:0] lo);
    return {op, 5'(rd), 5'(rs), 5'(rt), lo};
  endfunction

  function automatic bit f_valid(logic [31:0] w);
    return w[31:30] == 2'b01;
  endfunction

  function automatic bit f_reads_rt(logic [31:0] w);
    return f_valid(w) && !w[29] && (w[31:26] != 6'b010001);
  endfunction

  function automatic bit m_hazard();
    int rs;
    int rt;
    bit haz;
    haz = 1'b0;
    if (!m_pv || !f_valid(m_pi)) return 1'b0;
    rs = int'(m_pi[20:16]);
    rt = int'(m_pi[15:11]);
    for (int k = 0; k < trace.size() && k < int'(HAZ_DEPTH); k++)
      if (trace[k] >= 0 && (trace[k] == rs || (f_reads_rt(m_pi) && trace[k] == rt))) haz = 1'b1;
    return haz;
  endfunction

  task automatic m_push(int d);
    trace.push_front(d);
    if (trace.size() > int'(HAZ_DEPTH)) void'(trace.pop_back());
  endtask

  task automatic m_reset();
    m_pv = 1'b0; m_pi = '0; trace.delete();
    m_out = '0; m_val = 1'b0; m_icnt = 0; m_scnt = 0;
  endtask

  task automatic apply_reset();
    Reset_n = 1'b0;
    #3;
    Reset_n = 1'b1;
    m_reset();
    src_q.delete();
  endtask

  // One clock: present head of src_q, sample ready at negedge, advance model at posedge.
  task automatic step(bit flush);
    bit          v;
    bit          haz;
    bit          iss;
    logic [31:0] w;
    v = src_q.size() > 0;
    w = v ? src_q[0] : 32'($urandom());
    InstrValid = v; InstrIn = w; Flush = flush;
    @(negedge Clk);
    haz = m_hazard();
    iss = m_pv && !haz && !flush;
    exp_ready = !flush && (!m_pv || iss);
    obs_ready = InstrReady;
    accepted  = v && (obs_ready === 1'b1);
    @(posedge Clk);
    if (flush) begin
      m_pv = 1'b0; trace.delete(); m_out = '0; m_val = 1'b0;
    end else begin
      if (iss && f_valid(m_pi)) begin
        m_out = m_pi; m_val = 1'b1; m_push(int'(m_pi[25:21]));
        if (m_icnt < CNT_MAX) m_icnt++;
      end else begin
        m_out = '0; m_val = 1'b0; m_push(-1);
        if (m_pv && !iss && m_scnt < CNT_MAX) m_scnt++;
      end
      if (v && exp_ready) begin m_pv = 1'b1; m_pi = w; end
      else if (iss) m_pv = 1'b0;
    end
    if (accepted) void'(src_q.pop_front());
    #1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; InstrValid = 1'b1; InstrIn = ADDI; Flush = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    checks++; if (IssueValid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid got %b want 0", IssueValid); end
    checks++; if (IssueInstr !== 32'h0) begin errors++; $display("FAIL reset_issue_instr got %h want 0", IssueInstr); end
    checks++; if (InstrReady !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", InstrReady); end
    checks++; if ({IssueCount, StallCount} !== '0) begin errors++; $display("FAIL reset_counters got ic=%0d sc=%0d want 0 0", IssueCount, StallCount); end
    Reset_n = 1'b1;
    m_reset();
    src_q.delete();
    src_q.push_back(ADDI);
    step(1'b0);
    checks++; if (accepted !== 1'b1 || IssueValid !== 1'b0) begin errors++; $display("FAIL reset_first_accept got acc=%b v=%b want 1 0", accepted, IssueValid); end
    step(1'b0);
    checks++; if (IssueInstr !== ADDI || IssueValid !== 1'b1 || IssueCount !== 4'd1) begin
      errors++; $display("FAIL reset_first_issue got %h v=%b ic=%0d want %h 1 1", IssueInstr, IssueValid, IssueCount, ADDI); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] outs[4];
    int          not_ready;
    apply_reset();
    src_q.push_back(ADDI); src_q.push_back(ORI);
    not_ready = 0;
    for (int c = 0; c < 4; c++) begin
      step(1'b0);
      outs[c] = IssueInstr;
      if (obs_ready !== 1'b1) not_ready++;
      checks++;
      if ({obs_ready, IssueValid, IssueInstr, IssueCount, StallCount} !== {exp_ready, m_val, m_out, CNT_W'(m_icnt), CNT_W'(m_scnt)}) begin
        errors++; $display("FAIL b2b_cyc%0d got rdy=%b v=%b i=%h ic=%0d sc=%0d want rdy=%b v=%b i=%h ic=%0d sc=%0d",
          c, obs_ready, IssueValid, IssueInstr, IssueCount, StallCount, exp_ready, m_val, m_out, m_icnt, m_scnt); end
    end
    checks++; if (outs[1] !== ADDI || outs[2] !== ORI) begin errors++; $display("FAIL b2b_order got %h %h want %h %h", outs[1], outs[2], ADDI, ORI); end
    checks++; if (StallCount !== 4'd0 || not_ready != 0) begin errors++; $display("FAIL b2b_no_stall got sc=%0d ready_low=%0d want 0 0", StallCount, not_ready); end
  endtask

  task automatic test_raw_dist1();
    int ori_at;
    int add_at;
    int ready_low;
    apply_reset();
    src_q.push_back(ADDI); src_q.push_back(ORI); src_q.push_back(ADD);
    ori_at = -1; add_at = -1; ready_low = 0;
    for (int c = 0; c < 9; c++) begin
      step(1'b0);
      if (IssueInstr === ORI) ori_at = c;
      if (IssueInstr === ADD) add_at = c;
      if (obs_ready !== 1'b1) ready_low++;
      checks++;
      if ({obs_ready, IssueValid, IssueInstr, IssueCount, StallCount} !== {exp_ready, m_val, m_out, CNT_W'(m_icnt), CNT_W'(m_scnt)}) begin
        errors++; $display("FAIL raw1_cyc%0d got rdy=%b v=%b i=%h ic=%0d sc=%0d want rdy=%b v=%b i=%h ic=%0d sc=%0d",
          c, obs_ready, IssueValid, IssueInstr, IssueCount, StallCount, exp_ready, m_val, m_out, m_icnt, m_scnt); end
    end
    checks++; if (add_at - ori_at != 3 || ori_at < 0) begin errors++; $display("FAIL raw1_distance got ori@%0d add@%0d want gap 3", ori_at, add_at); end
    checks++; if (StallCount !== 4'd2) begin errors++; $display("FAIL raw1_stalls got %0d want 2", StallCount); end
    checks++; if (ready_low != 2) begin errors++; $display("FAIL raw1_ready_low got %0d want 2", ready_low); end
  endtask

  task automatic test_raw_dist2();
    logic [31:0] addi2;
    logic [31:0] andi;
    logic [31:0] sub;
    int          and_at;
    int          sub_at;
    addi2 = mk(6'b011010, 1, 2, 0, 11'd15);
    andi  = mk(6'b010100, 5, 6, 0, 11'd0);
    sub   = mk(6'b010011, 4, 1, 6, 11'd0);
    apply_reset();
    src_q.push_back(addi2); src_q.push_back(andi); src_q.push_back(sub);
    and_at = -1; sub_at = -1;
    for (int c = 0; c < 8; c++) begin
      step(1'b0);
      if (IssueInstr === andi) and_at = c;
      if (IssueInstr === sub) sub_at = c;
      checks++;
      if ({obs_ready, IssueValid, IssueInstr, IssueCount, StallCount} !== {exp_ready, m_val, m_out, CNT_W'(m_icnt), CNT_W'(m_scnt)}) begin
        errors++; $display("FAIL raw2_cyc%0d got rdy=%b v=%b i=%h ic=%0d sc=%0d want rdy=%b v=%b i=%h ic=%0d sc=%0d",
          c, obs_ready, IssueValid, IssueInstr, IssueCount, StallCount, exp_ready, m_val, m_out, m_icnt, m_scnt); end
    end
    checks++; if (sub_at - and_at != 2 || and_at < 0) begin errors++; $display("FAIL raw2_distance got and@%0d sub@%0d want gap 2", and_at, sub_at); end
    checks++; if (StallCount !== 4'd1 || IssueCount !== 4'd3) begin errors++; $display("FAIL raw2_counts got sc=%0d ic=%0d want 1 3", StallCount, IssueCount); end
  endtask

  task automatic test_not_invalid();
    logic [31:0] outs[6];
    bit          vals[6];
    apply_reset();
    src_q.push_back(ORI); src_q.push_back(NOTI); src_q.push_back(32'h0);
    for (int c = 0; c < 6; c++) begin
      step(1'b0);
      outs[c] = IssueInstr; vals[c] = IssueValid;
      checks++;
      if ({obs_ready, IssueValid, IssueInstr, IssueCount, StallCount} !== {exp_ready, m_val, m_out, CNT_W'(m_icnt), CNT_W'(m_scnt)}) begin
        errors++; $display("FAIL notinv_cyc%0d got rdy=%b v=%b i=%h ic=%0d sc=%0d want rdy=%b v=%b i=%h ic=%0d sc=%0d",
          c, obs_ready, IssueValid, IssueInstr, IssueCount, StallCount, exp_ready, m_val, m_out, m_icnt, m_scnt); end
    end
    checks++; if (outs[1] !== ORI || outs[2] !== NOTI) begin errors++; $display("FAIL not_no_stall got %h %h want %h %h", outs[1], outs[2], ORI, NOTI); end
    checks++; if (vals[3] !== 1'b0 || outs[3] !== 32'h0 || src_q.size() != 0) begin
      errors++; $display("FAIL invalid_consumed got v=%b i=%h left=%0d want 0 0 0", vals[3], outs[3], src_q.size()); end
    checks++; if (IssueCount !== 4'd2 || StallCount !== 4'd0) begin errors++; $display("FAIL notinv_counts got ic=%0d sc=%0d want 2 0", IssueCount, StallCount); end
  endtask

  task automatic test_reset_mid_stall();
    logic [31:0] sub;
    sub = mk(6'b010011, 4, 1, 6, 11'd0);
    apply_reset();
    src_q.push_back(ADDI); src_q.push_back(sub);
    repeat (3) step(1'b0);
    checks++; if (StallCount !== 4'd1) begin errors++; $display("FAIL midstall_setup got sc=%0d want 1", StallCount); end
    #1 Reset_n = 1'b0;
    #1;
    checks++; if ({IssueValid, IssueInstr, IssueCount, StallCount, InstrReady} !== {1'b0, 32'h0, 4'd0, 4'd0, 1'b1}) begin
      errors++; $display("FAIL midstall_reset got v=%b i=%h ic=%0d sc=%0d rdy=%b want 0 0 0 0 1", IssueValid, IssueInstr, IssueCount, StallCount, InstrReady); end
    Reset_n = 1'b1;
    m_reset(); src_q.delete();
    src_q.push_back(ORI);
    step(1'b0);
    step(1'b0);
    checks++; if (IssueInstr !== ORI || IssueValid !== 1'b1 || StallCount !== 4'd0 || IssueCount !== 4'd1) begin
      errors++; $display("FAIL midstall_after_reset got i=%h v=%b ic=%0d sc=%0d want %h 1 1 0", IssueInstr, IssueValid, IssueCount, StallCount, ORI); end
    step(1'b0);
    checks++; if (IssueValid !== 1'b0) begin errors++; $display("FAIL midstall_dropped got v=%b i=%h want 0", IssueValid, IssueInstr); end

    apply_reset();
    src_q.push_back(ADDI); src_q.push_back(sub);
    repeat (3) step(1'b0);
    step(1'b1);
    checks++; if ({obs_ready, IssueValid, IssueCount, StallCount} !== {1'b0, 1'b0, 4'd1, 4'd1}) begin
      errors++; $display("FAIL flush_cycle got rdy=%b v=%b ic=%0d sc=%0d want 0 0 1 1", obs_ready, IssueValid, IssueCount, StallCount); end
    src_q.delete();
    src_q.push_back(ORI);
    step(1'b0);
    step(1'b0);
    checks++; if (IssueInstr !== ORI || IssueCount !== 4'd2 || StallCount !== 4'd1) begin
      errors++; $display("FAIL flush_after got i=%h ic=%0d sc=%0d want %h 2 1", IssueInstr, IssueCount, StallCount, ORI); end
  endtask

  function automatic logic [31:0] gen();
    logic [5:0] op;
    int         kind;
    kind = int'($urandom_range(0, 9));
    op = 6'($urandom());
    if (kind < 4)      op[5:3] = 3'b010;
    else if (kind < 8) op[5:3] = 3'b011;
    else if (op[5:4] == 2'b01) op[5] = 1'b1;
    return mk(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), 11'($urandom()));
  endfunction

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      if (src_q.size() == 0 && $urandom_range(0, 9) < 7) src_q.push_back(gen());
      step($urandom_range(0, 29) == 0);
      checks++;
      if ({obs_ready, IssueValid, IssueInstr, IssueCount, StallCount} !== {exp_ready, m_val, m_out, CNT_W'(m_icnt), CNT_W'(m_scnt)}) begin
        errors++; $display("FAIL rand_cyc%0d got rdy=%b v=%b i=%h ic=%0d sc=%0d want rdy=%b v=%b i=%h ic=%0d sc=%0d",
          c, obs_ready, IssueValid, IssueInstr, IssueCount, StallCount, exp_ready, m_val, m_out, m_icnt, m_scnt); end
    end
    checks++; if (IssueCount !== 4'd15) begin errors++; $display("FAIL rand_saturate got ic=%0d want 15", IssueCount); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    m_reset();
    test_reset();
    test_back_to_back();
    test_raw_dist1();
    test_raw_dist2();
    test_not_invalid();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
